add_result_stage: RTL and testbench



---
 rtl/add_result_stage.sv | 131 +++++++++++++
 tb/tb_add_result_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/add_result_stage.sv
// add_result_stage
// Registered result stage behind the 32-bit carry-lookahead adder. It buffers
// {sum, cout, ovf} in a 2-entry valid/ready FIFO, keeps a sticky overflow flag
// and counts overflowing results in a saturating counter.
// Optional feature macro: SATURATE_EN. When it is defined, an overflowing sum is
// clamped to the signed extreme before it is stored.
module add_result_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inSum,
  input  logic              inCout,
  input  logic              inOvf,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outSum,
  output logic              outCout,
  output logic              outOvf,
  output logic              stickyOvf,
  output logic [CNT_W-1:0]  ovfCount,
  input  logic              clrSticky
);

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  entry_t           mem_q [2];
  entry_t           mem_d [2];
  entry_t           last_q, last_d;
  entry_t           head;
  entry_t           in_entry;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic [CNT_W-1:0] ovf_count_base;
  logic             push, pop;

  // Handshake flags come only from the registered occupancy.
  assign inReady  = (cnt_q != 2'd2);
  assign outValid = (cnt_q != 2'd0);
  assign push     = inValid & inReady;
  assign pop      = outValid & outReady;

  // Form the entry to store, clamping overflowing sums when saturation is built in.
  always_comb begin
    in_entry.sum  = inSum;
    in_entry.cout = inCout;
    in_entry.ovf  = inOvf;
`ifdef SATURATE_EN
    if (inOvf) begin
      // MSB set on an overflow means two positives wrapped negative.
      if (inSum[DATA_W-1]) in_entry.sum = {1'b0, {(DATA_W-1){1'b1}}};
      else                 in_entry.sum = {1'b1, {(DATA_W-1){1'b0}}};
    end
`endif
  end

  // Head entry drives the outputs; an empty buffer shows the last popped result.
  always_comb begin
    head    = mem_q[rd_ptr_q];
    outSum  = (cnt_q != 2'd0) ? head.sum  : last_q.sum;
    outCout = (cnt_q != 2'd0) ? head.cout : last_q.cout;
    outOvf  = (cnt_q != 2'd0) ? head.ovf  : last_q.ovf;
  end

  // Next-state for FIFO storage, pointers, occupancy and the last-popped holder.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      last_d   = head;
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  // Next-state for overflow status: a same-cycle overflow beats a clear.
  always_comb begin
    sticky_d       = (sticky_q & ~clrSticky) | (push & inOvf);
    ovf_count_base = clrSticky ? '0 : ovf_count_q;
    ovf_count_d    = ovf_count_base;
    if (push && inOvf && (ovf_count_base != CNT_MAX))
      ovf_count_d = ovf_count_base + 1'b1;
  end

  assign stickyOvf = sticky_q;
  assign ovfCount  = ovf_count_q;

  // State registers; reset discards every buffered entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too, because outputs must read 0 after reset.
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      last_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      sticky_q    <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      last_q      <= last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      ovf_count_q <= ovf_count_d;
    end
  end

endmodule

// File: tb/tb_add_result_stage.sv
// Directed testbench for add_result_stage. Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, away from the active edge.
module tb_add_result_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              inValid, inReady;
  logic [DATA_W-1:0] inSum;
  logic              inCout, inOvf;
  logic              outValid, outReady;
  logic [DATA_W-1:0] outSum;
  logic              outCout, outOvf;
  logic              stickyOvf;
  logic [CNT_W-1:0]  ovfCount;
  logic              clrSticky;

  int tests_run = 0;
  int tests_failed = 0;

  add_result_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(inReady),
    .inSum(inSum), .inCout(inCout), .inOvf(inOvf),
    .outValid(outValid), .outReady(outReady),
    .outSum(outSum), .outCout(outCout), .outOvf(outOvf),
    .stickyOvf(stickyOvf), .ovfCount(ovfCount), .clrSticky(clrSticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] s, input logic c, input logic o);
    inValid = v; inSum = s; inCout = c; inOvf = o;
  endtask

  initial begin
    logic [31:0] sat_exp;
    rst_n = 1'b0; outReady = 1'b0; clrSticky = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);  // pushes must be ignored in reset
    repeat (3) step();
    check("rst_outValid", {31'd0, outValid}, 32'd0);
    check("rst_inReady",  {31'd0, inReady},  32'd1);
    check("rst_outSum",   outSum,            32'd0);
    check("rst_outCout",  {31'd0, outCout},  32'd0);
    check("rst_outOvf",   {31'd0, outOvf},   32'd0);
    check("rst_sticky",   {31'd0, stickyOvf}, 32'd0);
    check("rst_count",    {24'd0, ovfCount}, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check("idle_outValid", {31'd0, outValid}, 32'd0);

    // Streaming with the consumer always ready: one-cycle latency, no bubbles.
    outReady = 1'b1;
    drive(1'b1, 32'd1, 1'b0, 1'b0); step();
    check("s1_valid", {31'd0, outValid}, 32'd1);
    check("s1_sum",   outSum, 32'd1);
    drive(1'b1, 32'd2, 1'b1, 1'b0); step();
    check("s2_sum",   outSum, 32'd2);
    check("s2_ready", {31'd0, inReady}, 32'd1);
    check("s2_cout",  {31'd0, outCout}, 32'd1);
    drive(1'b1, 32'd3, 1'b0, 1'b0); step();
    check("s3_sum",   outSum, 32'd3);
    check("s3_valid", {31'd0, outValid}, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0); step();
    check("s_empty_valid", {31'd0, outValid}, 32'd0);
    check("s_empty_hold",  outSum, 32'd3);

    // Back-pressure: fill, hold off a third result, then drain in order.
    outReady = 1'b0;
    drive(1'b1, 32'hAAAA_0000, 1'b0, 1'b0); step();
    check("bp1_ready", {31'd0, inReady}, 32'd1);
    check("bp1_sum",   outSum, 32'hAAAA_0000);
    drive(1'b1, 32'h5555_FFFF, 1'b0, 1'b0); step();
    check("bp2_ready", {31'd0, inReady}, 32'd0);
    check("bp2_sum",   outSum, 32'hAAAA_0000);
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0); step();
    check("bp3_held_ready", {31'd0, inReady}, 32'd0);
    check("bp3_held_sum",   outSum, 32'hAAAA_0000);
    outReady = 1'b1; step();
    check("bp_drain1_sum",   outSum, 32'h5555_FFFF);
    check("bp_drain1_ready", {31'd0, inReady}, 32'd1);
    step();
    check("bp_third_sum",   outSum, 32'h1234_5678);
    check("bp_third_valid", {31'd0, outValid}, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0); step();
    check("bp_empty", {31'd0, outValid}, 32'd0);

    // Overflowing result: sticky flag, counter, optional clamp.
`ifdef SATURATE_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h8000_0000;
`endif
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b1); step();
    check("ovf_sticky", {31'd0, stickyOvf}, 32'd1);
    check("ovf_count",  {24'd0, ovfCount}, 32'd1);
    check("ovf_sum",    outSum, sat_exp);
    check("ovf_outOvf", {31'd0, outOvf}, 32'd1);
    check("ovf_cout",   {31'd0, outCout}, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0); step();

    // Clear and overflow push in the same cycle: set wins, count restarts at 1.
    clrSticky = 1'b1;
    drive(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1); step();
    check("clrset_sticky", {31'd0, stickyOvf}, 32'd1);
    check("clrset_count",  {24'd0, ovfCount}, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0); step();
    check("clr_sticky", {31'd0, stickyOvf}, 32'd0);
    check("clr_count",  {24'd0, ovfCount}, 32'd0);
    clrSticky = 1'b0;

    // Saturating counter: 300 overflowing pushes stop at 255.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'h8000_0000 + i, 1'b0, 1'b1); step();
      if (i == 253) check("sat_count_254", {24'd0, ovfCount}, 32'd254);
      if (i == 254) check("sat_count_255", {24'd0, ovfCount}, 32'd255);
    end
    check("sat_count_hold", {24'd0, ovfCount}, 32'd255);
    check("sat_sticky",     {31'd0, stickyOvf}, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0); step();

    // Asynchronous reset while full empties the buffer at once.
    outReady = 1'b0;
    drive(1'b1, 32'h0000_00A1, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_00A2, 1'b0, 1'b0); step();
    check("full_ready", {31'd0, inReady}, 32'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, outValid}, 32'd0);
    check("arst_ready", {31'd0, inReady}, 32'd1);
    check("arst_sum",   outSum, 32'd0);
    check("arst_count", {24'd0, ovfCount}, 32'd0);
    check("arst_sticky", {31'd0, stickyOvf}, 32'd0);
    step();
    rst_n = 1'b1;
    outReady = 1'b1;
    step();
    check("post_rst_valid", {31'd0, outValid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
